l2_bus_responder: RTL

- Bus-side responder for the L2 cache's external bus operations.
- Accepts one READ / WRITE / INVALIDATE / RFO request at a time.
- Returns the snoop result that other caches report (HIT / HITM / NOHIT), after modelled HITM write-back and memory latency.
- Keeps saturating per-operation statistics. Sits between the L2 bus-operation port and the memory/snoop model, and replaces the L2's behavioural snoop-result lookup with a cycle-accurate handshaked agent.

---
 rtl/l2_bus_responder_if.sv | 24 ++
 rtl/l2_bus_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/l2_bus_responder_if.sv
// Handshaked request/response channel between the L2 bus-operation port and the bus responder.
interface l2_bus_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_snoop;
  logic [1:0]        rsp_op;
  logic [ADDR_W-1:0] rsp_addr;

  modport master (
    output req_valid, req_op, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_snoop, rsp_op, rsp_addr
  );

  modport slave (
    input  req_valid, req_op, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_snoop, rsp_op, rsp_addr
  );
endinterface

// File: rtl/l2_bus_responder.sv
// Bus-side responder: accepts one bus op, models snoop / HITM write-back / memory latency,
// returns the snoop result and keeps saturating per-operation statistics.
module l2_bus_responder #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_W    = 6,
  parameter int MEM_LATENCY = 4,
  parameter int WB_LATENCY  = 2,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  l2_bus_responder_if.slave       bus,
  output logic                    busy,
  input  logic                    stats_clr,
  output logic [CNT_W-1:0]        cnt_read,
  output logic [CNT_W-1:0]        cnt_write,
  output logic [CNT_W-1:0]        cnt_inval,
  output logic [CNT_W-1:0]        cnt_rfo,
  output logic [CNT_W-1:0]        cnt_hitm
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INVAL = 2'b10;
  localparam logic [1:0] OP_RFO   = 2'b11;

  localparam logic [1:0] SNP_HIT   = 2'b00;
  localparam logic [1:0] SNP_HITM  = 2'b01;
  localparam logic [1:0] SNP_NOHIT = 2'b10;

  localparam int MAX_LAT = (MEM_LATENCY > WB_LATENCY) ? MEM_LATENCY : WB_LATENCY;
  localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [LAT_W-1:0] MEM_LOAD = LAT_W'(MEM_LATENCY - 1);
  localparam logic [LAT_W-1:0] WB_LOAD  = LAT_W'(WB_LATENCY - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNOOP,
    S_WB,
    S_MEM,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_snoop_q, rsp_snoop_d;
  logic [1:0]        rsp_op_q, rsp_op_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [1:0]        addr_lo_q, addr_lo_d;

  logic              accept;
  logic              hitm;
  logic [1:0]        snoop_res;
  logic [4:0]        cnt_inc;
  logic [CNT_W-1:0]  cnt_all [5];

  assign accept = bus.req_valid && !busy_q;

  // Only READ and RFO see other caches' copies; the low address bits pick the modelled result.
  always_comb begin
    snoop_res = SNP_NOHIT;
    if (rsp_op_q == OP_READ || rsp_op_q == OP_RFO) begin
      case (addr_lo_q)
        2'b00:   snoop_res = SNP_HIT;
        2'b01:   snoop_res = SNP_HITM;
        default: snoop_res = SNP_NOHIT;
      endcase
    end
  end

  assign hitm = (snoop_res == SNP_HITM);

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    rsp_snoop_d = rsp_snoop_q;
    rsp_op_d    = rsp_op_q;
    rsp_addr_d  = rsp_addr_q;
    addr_lo_d   = addr_lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_SNOOP;
          rsp_op_d   = bus.req_op;
          rsp_addr_d = bus.req_addr & LINE_MASK;
          addr_lo_d  = bus.req_addr[1:0];
        end
      end
      S_SNOOP: begin
        rsp_snoop_d = snoop_res;
        if (hitm) begin
          state_d = S_WB;
          lat_d   = WB_LOAD;
        end else if (rsp_op_q == OP_INVAL) begin
          state_d = S_RESP;
        end else begin
          state_d = S_MEM;
          lat_d   = MEM_LOAD;
        end
      end
      S_WB: begin
        if (lat_q == '0) begin
          if (rsp_op_q == OP_INVAL) begin
            state_d = S_RESP;
          end else begin
            state_d = S_MEM;
            lat_d   = MEM_LOAD;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_MEM: begin
        if (lat_q == '0) begin
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The response is presented one cycle after RESP is entered so every field is already registered.
  assign rsp_valid_d = (state_q == S_RESP) && !(rsp_valid_q && bus.rsp_ready);
  assign busy_d      = (state_d != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_snoop_q <= SNP_NOHIT;
      rsp_op_q    <= OP_READ;
      rsp_addr_q  <= '0;
      addr_lo_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_snoop_q <= rsp_snoop_d;
      rsp_op_q    <= rsp_op_d;
      rsp_addr_q  <= rsp_addr_d;
      addr_lo_q   <= addr_lo_d;
    end
  end

  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = accept && (bus.req_op == OP_READ);
    cnt_inc[1] = accept && (bus.req_op == OP_WRITE);
    cnt_inc[2] = accept && (bus.req_op == OP_INVAL);
    cnt_inc[3] = accept && (bus.req_op == OP_RFO);
    cnt_inc[4] = (state_q == S_SNOOP) && hitm;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Clear has priority over a coincident increment; increments stop at all-ones.
      always_comb begin
        cnt_d = cnt_q;
        if (stats_clr) begin
          cnt_d = '0;
        end else if (cnt_inc[gi] && !(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_all[gi] = cnt_q;
    end
  endgenerate

  assign bus.req_ready = !busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_snoop = rsp_snoop_q;
  assign bus.rsp_op    = rsp_op_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign busy          = busy_q;

  assign cnt_read  = cnt_all[0];
  assign cnt_write = cnt_all[1];
  assign cnt_inval = cnt_all[2];
  assign cnt_rfo   = cnt_all[3];
  assign cnt_hitm  = cnt_all[4];

endmodule
